// File: rtl/dphy_tx_pkg.sv
// Shared types and constants for the D-PHY HS transmit path.
// Sequencer states, SoT sync byte and LP line-state encodings {DP,DN}.
package dphy_tx_pkg;

    typedef enum logic [2:0] {
        STOP,
        HS_RQST,
        HS_PREP,
        HS_ZERO,
        HS_SYNC,
        HS_DATA,
        HS_TRAIL,
        HS_EXIT
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

    // A timed state of n cycles loads its down counter with n-1.
    function automatic logic [7:0] tmr_init(input int n);
        return 8'(n - 1);
    endfunction

endpackage

// File: rtl/hs_tx_timer.sv
// Loadable 8-bit down counter shared by all timed sequencer states.
// last_o exists only when HS_SYNC_INSERT_EN is undefined.
module hs_tx_timer (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [7:0] val_i,
`ifndef HS_SYNC_INSERT_EN
    output logic       last_o,
`endif
    output logic       done_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    // Load on state entry, otherwise count down and rest at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = val_i;
        end else if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 8'd0);

`ifndef HS_SYNC_INSERT_EN
    assign last_o = (cnt_q == 8'd1);
`endif

endmodule

// File: rtl/hs_tx_sequencer.sv
// HS transmit sequencer for one D-PHY data lane (byte clock domain).
// HS_SYNC_INSERT_EN: when defined, the sequencer inserts the 0xB8 SoT byte.
module hs_tx_sequencer #(
    parameter int T_LPX        = 2,
    parameter int T_HS_PREPARE = 2,
    parameter int T_HS_ZERO    = 4,
    parameter int T_HS_TRAIL   = 2,
    parameter int T_HS_EXIT    = 3
) (
    input  logic       TX_BYTE_clk,
    input  logic       TX_rst_n,
    input  logic       TxRequestHS,
    input  logic [7:0] TxDataHS,
    output logic       TxReadyHS,
    output logic       Stopstate,
    output logic       LP_DP,
    output logic       LP_DN,
    output logic       HS_Enable,
    output logic [7:0] TX_BYTE_DATA
);

    import dphy_tx_pkg::*;

    localparam logic [7:0] LPX_INIT   = tmr_init(T_LPX);
    localparam logic [7:0] PREP_INIT  = tmr_init(T_HS_PREPARE);
    localparam logic [7:0] ZERO_INIT  = tmr_init(T_HS_ZERO);
    localparam logic [7:0] TRAIL_INIT = tmr_init(T_HS_TRAIL);
    localparam logic [7:0] EXIT_INIT  = tmr_init(T_HS_EXIT);

    tx_state_e  state_q, state_d;
    logic [1:0] lp_q, lp_d;
    logic       en_q, en_d;
    logic       rdy_q, rdy_d;
    logic       stop_q, stop_d;
    logic [7:0] data_q, data_d;

    logic       tmr_load;
    logic [7:0] tmr_val;
    logic       tmr_done;
`ifndef HS_SYNC_INSERT_EN
    logic       tmr_last;
`endif

    // Trail repeats the inverse of the last serial bit (MSB, sent last).
    logic [7:0] trail_byte;
    assign trail_byte = {8{~data_q[7]}};

    hs_tx_timer u_timer (
        .clk_i  (TX_BYTE_clk),
        .rst_ni (TX_rst_n),
        .load_i (tmr_load),
        .val_i  (tmr_val),
`ifndef HS_SYNC_INSERT_EN
        .last_o (tmr_last),
`endif
        .done_o (tmr_done)
    );

    // Next-state and next-output decode; a dropped request wins over timing.
    always_comb begin
        state_d  = state_q;
        lp_d     = lp_q;
        en_d     = en_q;
        rdy_d    = rdy_q;
        stop_d   = stop_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_val  = 8'd0;
        unique case (state_q)
            STOP: begin
                if (TxRequestHS) begin
                    state_d  = HS_RQST;
                    lp_d     = LP01;
                    stop_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = LPX_INIT;
                end
            end
            HS_RQST: begin
                if (!TxRequestHS) begin
                    state_d  = HS_EXIT;
                    lp_d     = LP11;
                    tmr_load = 1'b1;
                    tmr_val  = EXIT_INIT;
                end else if (tmr_done) begin
                    state_d  = HS_PREP;
                    lp_d     = LP00;
                    tmr_load = 1'b1;
                    tmr_val  = PREP_INIT;
                end
            end
            HS_PREP: begin
                if (!TxRequestHS) begin
                    state_d  = HS_EXIT;
                    lp_d     = LP11;
                    tmr_load = 1'b1;
                    tmr_val  = EXIT_INIT;
                end else if (tmr_done) begin
                    state_d  = HS_ZERO;
                    en_d     = 1'b1;
                    data_d   = 8'h00;
                    tmr_load = 1'b1;
                    tmr_val  = ZERO_INIT;
                end
            end
            HS_ZERO: begin
                if (!TxRequestHS) begin
                    state_d  = HS_TRAIL;
                    rdy_d    = 1'b0;
                    data_d   = trail_byte;
                    tmr_load = 1'b1;
                    tmr_val  = TRAIL_INIT;
                end else if (tmr_done) begin
`ifdef HS_SYNC_INSERT_EN
                    state_d = HS_SYNC;
                    data_d  = SYNC_BYTE;
                    rdy_d   = 1'b1;
`else
                    state_d = HS_DATA;
                    data_d  = TxDataHS;
`endif
                end
`ifndef HS_SYNC_INSERT_EN
                else if (tmr_last) begin
                    rdy_d = 1'b1;
                end
`endif
            end
`ifdef HS_SYNC_INSERT_EN
            HS_SYNC: begin
                if (!TxRequestHS) begin
                    state_d  = HS_TRAIL;
                    rdy_d    = 1'b0;
                    data_d   = trail_byte;
                    tmr_load = 1'b1;
                    tmr_val  = TRAIL_INIT;
                end else begin
                    state_d = HS_DATA;
                    data_d  = TxDataHS;
                end
            end
`endif
            HS_DATA: begin
                if (!TxRequestHS) begin
                    state_d  = HS_TRAIL;
                    rdy_d    = 1'b0;
                    data_d   = trail_byte;
                    tmr_load = 1'b1;
                    tmr_val  = TRAIL_INIT;
                end else begin
                    data_d = TxDataHS;
                end
            end
            HS_TRAIL: begin
                if (tmr_done) begin
                    state_d  = HS_EXIT;
                    en_d     = 1'b0;
                    data_d   = 8'h00;
                    lp_d     = LP11;
                    tmr_load = 1'b1;
                    tmr_val  = EXIT_INIT;
                end
            end
            HS_EXIT: begin
                if (tmr_done) begin
                    state_d = STOP;
                    stop_d  = 1'b1;
                end
            end
            default: begin
                state_d = STOP;
                lp_d    = LP11;
                en_d    = 1'b0;
                rdy_d   = 1'b0;
                stop_d  = 1'b1;
                data_d  = 8'h00;
            end
        endcase
    end

    // State and registered outputs; reset drops the lane straight to LP-11.
    always_ff @(posedge TX_BYTE_clk or negedge TX_rst_n) begin
        if (!TX_rst_n) begin
            state_q <= STOP;
            lp_q    <= LP11;
            en_q    <= 1'b0;
            rdy_q   <= 1'b0;
            stop_q  <= 1'b1;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            lp_q    <= lp_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            stop_q  <= stop_d;
            data_q  <= data_d;
        end
    end

    assign LP_DP        = lp_q[1];
    assign LP_DN        = lp_q[0];
    assign HS_Enable    = en_q;
    assign TxReadyHS    = rdy_q;
    assign Stopstate    = stop_q;
    assign TX_BYTE_DATA = data_q;

endmodule

// File: tb/tb_hs_tx_sequencer.sv
// Scoreboard bench for hs_tx_sequencer.
// Timeline model pushes expected outputs.
module tb_hs_tx_sequencer;

  localparam int L = 2;
  localparam int P = 2;
  localparam int Z = 4;
  localparam int T = 2;
  localparam int X = 3;
`ifdef HS_SYNC_INSERT_EN
  localparam int S = 1;
`else
  localparam int S = 0;
`endif
  localparam int Z0 = 1 + L + P;
  localparam int D0 = Z0 + Z + S;

  typedef struct packed {
    logic       dp;
    logic       dn;
    logic       en;
    logic       rdy;
    logic       stop;
    logic [7:0] data;
  } obs_t;

  localparam obs_t IDLE = '{
    dp: 1'b1, dn: 1'b1, en: 1'b0,
    rdy: 1'b0, stop: 1'b1, data: 8'h00
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] din;
  logic       rdy, stop, dp, dn, en;
  logic [7:0] dout;

  obs_t       exp_q[$];
  logic [7:0] pl[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         de, xs, se;

  always #5 clk = ~clk;

  hs_tx_sequencer #(
    .T_LPX        (L),
    .T_HS_PREPARE (P),
    .T_HS_ZERO    (Z),
    .T_HS_TRAIL   (T),
    .T_HS_EXIT    (X)
  ) dut (
    .TX_BYTE_clk  (clk),
    .TX_rst_n     (rst_n),
    .TxRequestHS  (req),
    .TxDataHS     (din),
    .TxReadyHS    (rdy),
    .Stopstate    (stop),
    .LP_DP        (dp),
    .LP_DN        (dn),
    .HS_Enable    (en),
    .TX_BYTE_DATA (dout)
  );

  function automatic logic [7:0] byte_at(
    input int e
  );
    if (S == 1 && e == Z0 + Z)
      return 8'hB8;
    if (e >= D0 && (e - D0) < pl.size())
      return pl[e - D0];
    return 8'h00;
  endfunction

  function automatic obs_t expect_at(
    input int e
  );
    obs_t       o;
    logic [7:0] b;
    o = IDLE;
    if (e >= se) return o;
    o.stop = 1'b0;
    if (e < de) begin
      if (e <= L) begin
        o.dp = 1'b0;
      end else if (e <= L + P) begin
        o.dp = 1'b0;
        o.dn = 1'b0;
      end else begin
        o.dp   = 1'b0;
        o.dn   = 1'b0;
        o.en   = 1'b1;
        o.data = byte_at(e);
        o.rdy  = (e >= Z0 + Z) ||
                 (S == 0 && e == Z0 + Z - 1);
      end
    end else if (e < xs) begin
      b      = byte_at(de - 1);
      o.dp   = 1'b0;
      o.dn   = 1'b0;
      o.en   = 1'b1;
      o.data = {8{~b[7]}};
    end
    return o;
  endfunction

  task automatic chk_rst(input string tag);
    obs_t a;
    a = {dp, dn, en, rdy, stop, dout};
    checks++;
    if (a !== IDLE) begin
      errors++;
      $display("FAIL rst %s: got %h want %h",
               tag, a, IDLE);
    end
  endtask

  task automatic fill(input int n);
    pl.delete();
    for (int i = 0; i < n; i++)
      pl.push_back(8'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 1'b0;
      din = 8'($urandom);
      @(posedge clk);
      #1;
      exp_q.push_back(IDLE);
    end
  endtask

  task automatic burst(
    input int drop,
    input int gap,
    input int rst_e
  );
    de = drop;
    xs = (de <= Z0) ? de : de + T;
    se = xs + X;
    for (int e = 1; e <= se + gap; e++) begin
      if (e < de)
        req = 1'b1;
      else if (e > xs && e <= se)
        req = 1'($urandom_range(0, 1));
      else
        req = 1'b0;
      din = (e >= D0 && e < de) ?
            pl[e - D0] : 8'($urandom);
      @(posedge clk);
      #1;
      if (e == rst_e) begin
        exp_q.push_back(IDLE);
        #1;
        rst_n = 1'b0;
        req   = 1'b0;
        #1;
        chk_rst("mid-burst");
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        return;
      end
      exp_q.push_back(expect_at(e));
    end
  endtask

  always @(negedge clk) begin
    obs_t a;
    obs_t x;
    cyc++;
    if (exp_q.size() != 0) begin
      a = {dp, dn, en, rdy, stop, dout};
      x = exp_q.pop_front();
      checks++;
      if (a !== x) begin
        errors++;
        $display("FAIL out cyc %0d: got %h want %h",
                 cyc, a, x);
      end
    end
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout: stimulus did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int d;
    rst_n = 1'b0;
    req   = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk_rst("power-on");
    #2;
    rst_n = 1'b1;
    idle(20);

    pl = '{8'hA5, 8'h3C};
    burst(D0 + 2, 2, 0);

    pl = '{8'h5A, 8'h11, 8'h80};
    burst(D0 + 3, 1, 0);

    pl.delete();
    burst(Z0, 2, 0);
    burst(2, 0, 0);
    burst(Z0 + 2, 1, 0);
    burst(Z0 + Z - 1, 1, 0);
    burst(D0, 1, 0);

    fill(6);
    burst(D0 + 6, 0, D0 + 2);
    idle(3);
    pl = '{8'hC3, 8'h7E};
    burst(D0 + 2, 2, 0);

    for (int k = 0; k < 25; k++) begin
      d = $urandom_range(2, D0 + 8);
      fill((d > D0) ? d - D0 : 0);
      burst(d, $urandom_range(0, 3), 0);
    end

    idle(2);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_tx_sequencer.md
# hs_tx_sequencer

HS transmit sequencer for one D-PHY data lane, clocked by the byte clock and sitting directly upstream of the Serializer. It accepts payload bytes over a PPI-style request/ready handshake. It then emits the byte-wide HS burst: HS-zero, the SoT sync byte, the payload, and the trail. It also generates the `Enable` for the Serializer and drives the LP line state for the low-power driver.

## Interface
- `T_LPX`, 2: byte-clock cycles in LP-01 (HS-request); range 1..255
- `T_HS_PREPARE`, 2: cycles in LP-00 before HS drive; range 1..255
- `T_HS_ZERO`, 4: cycles of 0x00 HS-zero bytes; range 2..255
- `T_HS_TRAIL`, 2: cycles of trail byte; range 1..255
- `T_HS_EXIT`, 3: LP-11 cycles before a new request is honoured; range 1..255
- `TX_BYTE_clk`  in  1  byte clock, the only clock
- `TX_rst_n`  in  1  asynchronous, active-low reset
- `TxRequestHS`  in  1  PPI request; high for the whole burst
- `TxDataHS`  in  8  payload byte; transmitted LSB first downstream
- `TxReadyHS`  out  1  byte accepted on any edge where `TxReadyHS` and `TxRequestHS` are both high
- `Stopstate`  out  1  lane idle in LP-11 and ready
- `LP_DP`, `LP_DN`  out  1 each  LP line state
- `HS_Enable`  out  1  drives the Serializer `Enable` and the HS driver enable
- `TX_BYTE_DATA`  out  8  byte to the Serializer

## Operation
- All outputs are registered.
- Reset values: `LP_DP`=1, `LP_DN`=1, `HS_Enable`=0, `TX_BYTE_DATA`=0x00, `TxReadyHS`=0, `Stopstate`=1, state STOP.
- STOP: LP-11, `Stopstate`=1. `TxRequestHS`=1 causes HS_RQST on the next edge.
- HS_RQST: LP-01 (`LP_DP`=0, `LP_DN`=1) for `T_LPX` cycles, then HS_PREP.
- HS_PREP: LP-00 for `T_HS_PREPARE` cycles, then HS_ZERO.
- HS_ZERO: `HS_Enable`=1, LP-00, `TX_BYTE_DATA`=0x00 for `T_HS_ZERO` cycles, then HS_SYNC.
- HS_SYNC: `TX_BYTE_DATA`=0xB8 for 1 cycle, with `TxReadyHS`=1.
- HS_DATA: on each accept edge, `TX_BYTE_DATA`<=`TxDataHS`. `TxReadyHS` stays 1 with no gaps.
- Leaving HS_DATA: an edge with `TxReadyHS`=1 and `TxRequestHS`=0 gives `TxReadyHS`<=0 and enters HS_TRAIL.
- Trail byte is {8{~b}}, where b is bit 7 of the last byte driven on `TX_BYTE_DATA`, i.e. the last serial bit inverted.
- HS_TRAIL: lasts `T_HS_TRAIL` cycles with `HS_Enable`=1, then HS_EXIT.
- HS_EXIT: `HS_Enable`=0, LP-11, `TX_BYTE_DATA`=0x00, `Stopstate`=0 for `T_HS_EXIT` cycles, then STOP. `TxRequestHS` is ignored until STOP.
- `TxRequestHS` falls during HS_RQST or HS_PREP: go to HS_EXIT next edge (no HS drive).
- `TxRequestHS` falls during HS_ZERO or HS_SYNC: go to HS_TRAIL next edge, with the trail byte derived by the same bit-7 rule (0xFF after zeros, 0x00 after 0xB8).
- Reset asserted mid-burst: all outputs return to reset values immediately (asynchronous); no trail is sent.
- Timed-state counter: 8-bit down counter, loaded with N-1 on entry; the state is left when the counter reaches 0.

## Timing
- Request is sampled at edge 0. HS_RQST starts at edge 1, HS_PREP at 1+`T_LPX`, HS_ZERO at 1+`T_LPX`+`T_HS_PREPARE`.
- `TxReadyHS` rises at edge 1+`T_LPX`+`T_HS_PREPARE`+`T_HS_ZERO` (defaults: edge 9). The first payload byte appears on `TX_BYTE_DATA` one edge later.
- Accept-to-output latency: 1 cycle. Throughput: 1 byte per cycle.
- Burst length in cycles: SoT + N payload bytes + `T_HS_TRAIL`.

## Configuration
- `HS_SYNC_INSERT_EN` defined: HS_SYNC state present, 0xB8 inserted as described.
- `HS_SYNC_INSERT_EN` undefined: no HS_SYNC state; the sync byte is the protocol layer's responsibility.
  - `TxReadyHS` is instead asserted on entry to the last HS_ZERO cycle, so it rises at edge `T_LPX`+`T_HS_PREPARE`+`T_HS_ZERO`.
  - The first payload byte follows the zeros directly.

## Structure
- Shared package `dphy_tx_pkg`:
  - state enum (STOP, HS_RQST, HS_PREP, HS_ZERO, HS_SYNC, HS_DATA, HS_TRAIL, HS_EXIT)
  - `SYNC_BYTE`=8'hB8
  - LP state constants LP11/LP01/LP00
- Sub-module `hs_tx_timer`: 8-bit loadable down counter with a `done` flag, shared by all timed states.

## Test plan
- Reset, then hold `TxRequestHS`=0 for 20 cycles -> outputs stay at reset values, `Stopstate`=1.
- Defaults, macro on, request with payload A5,3C -> LP sequence 11,01×2,00×2.
  - `TX_BYTE_DATA` sequence: 00×4, B8, A5, 3C, FF×2 (3C bit7=0), then 00.
  - `HS_Enable` high for 9 cycles; `TxReadyHS` high on edges 9–11.
- Macro off, same stimulus -> 00×4, A5, 3C, FF×2; `TxReadyHS` rises at edge 8.
- Payload ending 0x80 -> trail bytes 0x00.
- Request dropped in the 2nd HS_PREP cycle -> no `HS_Enable`; LP-11 for 3 cycles, then `Stopstate`=1.
- `TX_rst_n` pulsed low during HS_DATA -> outputs reset asynchronously; the next request restarts from HS_RQST.
